instruction_fetch_queue: RTL

Next-generation fetch stage. It decouples PC generation from decode with a parametrised prefetch queue, a valid/ready handshake toward decode, and flush-on-redirect. It drives an external synchronous-read instruction memory with fixed 1-cycle latency. It sits between the instruction memory and the IF/ID boundary, replacing the single-register fetch stage.

---
 rtl/instruction_fetch_queue_pkg.sv | 21 ++
 rtl/instruction_fetch_queue_if.sv | 25 ++
 rtl/instruction_fetch_queue_fetch_queue.sv | 57 +++++
 rtl/instruction_fetch_queue.sv | 131 +++++++++++++
 4 files changed

// File: rtl/instruction_fetch_queue_pkg.sv
// Shared definitions for the prefetching fetch stage.
// Covers redirect-select encodings, the PC step, and the ceil-log2 helper.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        SEL_NONE     = 2'd0,
        SEL_BRANCH   = 2'd1,
        SEL_JUMP_RS  = 2'd2,
        SEL_JUMP_INM = 2'd3
    } redirect_sel_e;

    localparam int PC_INC = 4;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Instruction-memory read port plus the decode-facing valid/ready head port.
// Decode handshake: the head transfers on any edge where o_valid & i_ready; o_ir/o_pc hold while o_valid & ~i_ready.
interface instruction_fetch_queue_if #(
    parameter int NB_REG   = 32,
    parameter int NB_INSTR = 32,
    parameter int NB_ADDR  = 11
);
    logic                o_imem_en;
    logic [NB_ADDR-1:0]  o_imem_addr;
    logic [NB_INSTR-1:0] i_imem_data;
    logic                o_valid;
    logic                i_ready;
    logic [NB_INSTR-1:0] o_ir;
    logic [NB_REG-1:0]   o_pc;

    modport master (
        output o_imem_en, o_imem_addr, o_valid, o_ir, o_pc,
        input  i_imem_data, i_ready
    );

    modport slave (
        input  o_imem_en, o_imem_addr, o_valid, o_ir, o_pc,
        output i_imem_data, i_ready
    );
endinterface

// File: rtl/instruction_fetch_queue_fetch_queue.sv
// Circular prefetch FIFO.
// Pointers wrap naturally because DEPTH is a power of two; flush empties it in one edge.
module fetch_queue
    import instr_fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = clogb2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop & ~empty;
    // Masking the head keeps the outputs at zero whenever nothing is queued.
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge i_clock) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Prefetching fetch stage: issues sequential reads to a 1-cycle imem, queues responses
// toward decode, and flushes on branch/jump redirects.
module instruction_fetch_queue
    import instr_fetch_pkg::*;
#(
    parameter int NB_REG      = 32,
    parameter int NB_INSTR    = 32,
    parameter int NB_INM_I    = 16,
    parameter int NB_INM_J    = 26,
    parameter int NB_ADDR     = 11,
    parameter int QUEUE_DEPTH = 4,
    parameter logic [NB_REG-1:0] RESET_PC = '0
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_valid,
    instruction_fetch_queue_if.master     bus,
    input  logic                          i_branch,
    input  logic                          i_jump_rs,
    input  logic                          i_jump_inm,
    input  logic [NB_REG-1:0]             i_base_pc,
    input  logic [NB_INM_I-1:0]           i_inm_i,
    input  logic [NB_INM_J-1:0]           i_inm_j,
    input  logic [NB_REG-1:0]             i_rs,
    output logic                          o_misaligned,
    output logic [clogb2(QUEUE_DEPTH):0]  o_count,
    output logic [NB_REG-1:0]             o_fetch_pc
);
    localparam int CW = clogb2(QUEUE_DEPTH) + 1;
    localparam int QW = NB_INSTR + NB_REG;

    redirect_sel_e     sel;
    logic              redirect;
    logic [NB_REG-1:0] branch_off;
    logic [NB_REG-1:0] target_raw;
    logic [NB_REG-1:0] target;

    logic [NB_REG-1:0] fetch_pc;
    logic [NB_REG-1:0] issued_pc;
    logic              inflight;
    logic              misaligned;

    logic              issue;
    logic              push;
    logic              pop;
    logic              head_valid;
    logic              full;
    logic              empty;
    logic [QW-1:0]     head;
    logic [CW-1:0]     count;
    logic [CW:0]       occupancy;

    // Multiple simultaneous redirect requests are treated as no redirect at all.
    always_comb begin
        sel = SEL_NONE;
        case ({i_branch, i_jump_rs, i_jump_inm})
            3'b100:  sel = SEL_BRANCH;
            3'b010:  sel = SEL_JUMP_RS;
            3'b001:  sel = SEL_JUMP_INM;
            default: sel = SEL_NONE;
        endcase
    end

    assign redirect   = i_valid & (sel != SEL_NONE);
    assign branch_off = {{(NB_REG-NB_INM_I-2){i_inm_i[NB_INM_I-1]}}, i_inm_i, 2'b00};

    always_comb begin
        target_raw = i_rs;
        case (sel)
            SEL_BRANCH:   target_raw = i_base_pc + branch_off;
            SEL_JUMP_INM: target_raw = {i_base_pc[NB_REG-1:NB_REG-4], i_inm_j, 2'b00};
            default:      target_raw = i_rs;
        endcase
    end

    assign target = {target_raw[NB_REG-1:2], 2'b00};

    // Slots already promised (queued + in flight) minus the one leaving this edge.
    assign occupancy  = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue      = ~i_reset & i_valid & ~redirect & (occupancy < (CW+1)'(QUEUE_DEPTH));
    assign push       = inflight & ~redirect;
    assign head_valid = i_valid & ~empty;
    assign pop        = head_valid & bus.i_ready;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            fetch_pc   <= RESET_PC;
            issued_pc  <= '0;
            inflight   <= 1'b0;
            misaligned <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= target;
            inflight <= 1'b0;
            if (target_raw[1:0] != 2'b00) misaligned <= 1'b1;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc  <= fetch_pc + NB_REG'(PC_INC);
                issued_pc <= fetch_pc;
            end
        end
    end

    fetch_queue #(
        .WIDTH (QW),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_data ({bus.i_imem_data, issued_pc + NB_REG'(PC_INC)}),
        .head_data (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assert property (@(posedge i_clock) disable iff (i_reset) !(push && full && !pop));

    assign bus.o_imem_en   = issue;
    assign bus.o_imem_addr = fetch_pc[NB_ADDR+1:2];
    assign bus.o_valid     = head_valid;
    assign bus.o_ir        = head[QW-1:NB_REG];
    assign bus.o_pc        = head[NB_REG-1:0];
    assign o_misaligned    = misaligned;
    assign o_count         = count;
    assign o_fetch_pc      = fetch_pc;

endmodule
